// File: rtl/quick_spi_pkg.sv
// quick_spi_pkg: shared definitions for the quick_spi master and slave.
// Contents: state encoding, byte/bit ordering constants, synchronizer depth,
// minimum sclk half-period and the word-position map used by both ends.
// Build macro: QUICK_SPI_SLAVE_SYNC3_EN selects 3-flop synchronizers.
package quick_spi_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam bit LITTLE_ENDIAN = 1'b0;
  localparam bit BIG_ENDIAN = 1'b1;
  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;
`ifdef QUICK_SPI_SLAVE_SYNC3_EN
  localparam int SYNC_STAGES = 3;
  localparam int MIN_SCLK_HALF_PERIOD = 5;
`else
  localparam int SYNC_STAGES = 2;
  localparam int MIN_SCLK_HALF_PERIOD = 4;
`endif
  // Word bit index carried by wire position k (k = 0 is the first bit on the bus).
  function automatic int map_pos(int k, int width, bit bytes_order, bit bits_order);
    int b;
    int i;
    b = k / 8;
    i = k % 8;
    return 8 * (bytes_order == BIG_ENDIAN ? width / 8 - 1 - b : b) + (bits_order == LSB_FIRST ? i : 7 - i);
  endfunction
endpackage

// File: rtl/quick_spi_sync_edge.sv
// quick_spi_sync_edge: multi-flop synchronizer with rise/fall detection.
// Ports: clk, reset (async, active high), d (asynchronous pin),
//        q (synchronized level), rise/fall (one-cycle pulses on q edges).
// INIT is the level the chain holds in reset.
module quick_spi_sync_edge #(
  parameter int STAGES = 2,
  parameter bit INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic q_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= {STAGES{INIT}};
      q_d <= INIT;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      q_d <= sr[STAGES-1];
    end
  end
  assign q = sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/quick_spi_slave.sv
// quick_spi_slave: SPI responder oversampling sclk/ss_n/mosi in the clk domain.
// Ports: clk, reset (async, active high), enable, sclk/ss_n/mosi (bus pins),
//        miso/miso_oe (slave data + pad enable), tx_data/tx_ack (word to send,
//        pulse on capture), rx_data/rx_valid (last word, pulse on update),
//        frame_error (deselect mid-word), busy (ACTIVE).
// Build macro: QUICK_SPI_SLAVE_SYNC3_EN uses 3-flop pin synchronizers.
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter int DATA_WIDTH = 16,
  parameter bit BYTES_ORDER = LITTLE_ENDIAN,
  parameter bit BITS_ORDER = MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ack,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int KW = $clog2(DATA_WIDTH);
  state_t state;
  logic [KW-1:0] k, k_next;
  logic [DATA_WIDTH-1:0] tx_seq, tx_perm, rx_seq, rx_word;
  logic word_done, active, last, lead, trail, sample, shift, start, deselect;
  logic sclk_rise, sclk_fall, ss_q, ss_rise, ss_fall, mosi_q;
  logic unused_sclk_level;
  logic [1:0] unused_mosi_edges;
  quick_spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(CPOL)) u_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  // Reset to 0 so ss_n held low through reset never looks like a fresh select.
  quick_spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_ss (
    .clk(clk), .reset(reset), .d(ss_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  quick_spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_q), .rise(unused_mosi_edges[0]), .fall(unused_mosi_edges[1])
  );
  // Words are kept in wire order: bit k of tx_seq/rx_seq is bus position k.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_map
    localparam int P = map_pos(i, DATA_WIDTH, BYTES_ORDER, BITS_ORDER);
    assign tx_perm[i] = tx_data[P];
    assign rx_word[P] = rx_seq[i];
  end
  always_comb begin
    active = state == ACTIVE;
    lead = CPOL ? sclk_fall : sclk_rise;
    trail = CPOL ? sclk_rise : sclk_fall;
    sample = active && (CPHA ? trail : lead);
    shift = active && (CPHA ? lead : trail);
    last = k == KW'(DATA_WIDTH - 1);
    k_next = sample ? (last ? '0 : k + KW'(1)) : k;
    // A completed word restarts only while still selected.
    start = (!active && ss_fall) || (active && word_done && !ss_q);
    deselect = active && ss_rise;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      word_done <= 1'b0;
      tx_seq <= '0;
      rx_seq <= '0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      tx_ack <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_error <= 1'b0;
      busy <= 1'b0;
    end else begin
      tx_ack <= 1'b0;
      rx_valid <= 1'b0;
      frame_error <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        k <= '0;
        word_done <= 1'b0;
        miso <= 1'b0;
        miso_oe <= 1'b0;
        busy <= 1'b0;
      end else begin
        if (word_done) begin
          rx_data <= rx_word;
          rx_valid <= 1'b1;
          word_done <= 1'b0;
        end
        if (sample) begin
          rx_seq[k] <= mosi_q;
          k <= k_next;
          if (last) word_done <= 1'b1;
        end
        if (shift) miso <= tx_seq[k];
        if (start) begin
          state <= ACTIVE;
          busy <= 1'b1;
          miso_oe <= 1'b1;
          tx_seq <= tx_perm;
          tx_ack <= 1'b1;
          k <= '0;
          if (!CPHA) miso <= tx_perm[0];
        end
        // The sample of this cycle is already folded into k_next.
        if (deselect) begin
          state <= IDLE;
          busy <= 1'b0;
          miso_oe <= 1'b0;
          miso <= 1'b0;
          k <= '0;
          frame_error <= k_next != '0;
        end
      end
    end
  end
endmodule
